// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the RV32I/RV64I immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decode.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_sh5, w_sh6;
    logic            w_is_shift;

    assign w_imm_i    = XLEN'($signed(inst[31:20]));
    assign w_imm_s    = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign w_imm_b    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign w_imm_u    = XLEN'($signed({inst[31:12], 12'b0}));
    assign w_imm_j    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign w_sh5      = XLEN'(inst[24:20]);
    assign w_sh6      = XLEN'(inst[25:20]);
    assign w_is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_OP_IMM: begin
                fmt = w_is_shift ? FMT_SH : FMT_I;
                imm = w_is_shift ? (RV64 ? w_sh6 : w_sh5) : w_imm_i;
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = w_imm_i;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = w_imm_s;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = w_imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = w_imm_u;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = w_imm_j;
            end
            OPC_OP_IMM32: begin
                // word shifts only ever take a 5-bit shamt
                if (RV64) begin
                    fmt = w_is_shift ? FMT_SH : FMT_I;
                    imm = w_is_shift ? w_sh5 : w_imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP32:                        illegal = !RV64;
            OPC_OP, OPC_FENCE, OPC_SYSTEM:   illegal = 1'b0;
            default:                         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on the input side, registered result
// with either a single output register or a two-entry skid buffer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int W = XLEN + 4;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic [W-1:0]    w_dec;
    logic            w_acc, w_xfer;
    logic [W-1:0]    r_out;
    logic            r_out_vld;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .imm     (w_imm),
        .fmt     (w_fmt),
        .illegal (w_ill)
    );

    assign w_dec       = {w_imm, w_fmt, w_ill};
    assign w_acc       = in_valid && in_ready;
    assign w_xfer      = r_out_vld && out_ready;
    assign out_valid   = r_out_vld;
    assign out_imm     = r_out[W-1:4];
    assign out_fmt     = r_out[3:1];
    assign out_illegal = r_out[0];

    generate
        if (SKID == 0) begin : g_single
            assign in_ready = !rst && (!r_out_vld || out_ready);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out     <= '0;
                    r_out_vld <= 1'b0;
                end else if (w_acc) begin
                    r_out     <= w_dec;
                    r_out_vld <= 1'b1;
                end else if (w_xfer) begin
                    r_out_vld <= 1'b0;
                end
            end
        end else begin : g_skid
            skid_state_e  r_state, w_state_nxt;
            logic [W-1:0] r_skid;
            logic         r_rdy;

            // the register is preset during reset; gating keeps ready low meanwhile
            assign in_ready = r_rdy && !rst;

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_EMPTY: if (w_acc) w_state_nxt = ST_ONE;
                    ST_ONE: begin
                        if (w_acc && !w_xfer)      w_state_nxt = ST_TWO;
                        else if (!w_acc && w_xfer) w_state_nxt = ST_EMPTY;
                    end
                    ST_TWO:   if (w_xfer) w_state_nxt = ST_ONE;
                    default:  w_state_nxt = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= ST_EMPTY;
                    r_rdy     <= 1'b1;
                    r_out     <= '0;
                    r_skid    <= '0;
                    r_out_vld <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_rdy     <= (w_state_nxt != ST_TWO);
                    r_out_vld <= (w_state_nxt != ST_EMPTY);
                    case (r_state)
                        ST_EMPTY: if (w_acc) r_out <= w_dec;
                        ST_ONE: begin
                            if (w_acc && w_xfer) r_out  <= w_dec;
                            else if (w_acc)      r_skid <= w_dec;
                        end
                        ST_TWO:   if (w_xfer) r_out <= r_skid;
                        default:  ;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance 0 is XLEN=32/SKID=1, instance 1 is XLEN=64/SKID=0.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vld  = '0;
    logic [1:0]  ordy = '0;
    logic [31:0] inst [2];
    wire  [1:0]  irdy, ovld, oill;
    wire  [2:0]  ofmt [2];
    wire  [31:0] imm32;
    wire  [63:0] imm64;
    wire  [63:0] oimm [2];

    int tests = 0;
    int fails = 0;

    logic [67:0] sbq [2][$];
    logic [1:0]  held = '0;
    logic [67:0] hval [2];

    logic [6:0] pool [14] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                              7'h67, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73, 7'h7F};

    assign oimm[0] = {32'h0, imm32};
    assign oimm[1] = imm64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy[0]), .in_inst(inst[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .out_imm(imm32), .out_fmt(ofmt[0]),
        .out_illegal(oill[0])
    );

    imm_gen_pipe #(.XLEN(64), .SKID(0)) u_d64 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy[1]), .in_inst(inst[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .out_imm(imm64), .out_fmt(ofmt[1]),
        .out_illegal(oill[1])
    );

    // Reference: immediates computed as signed integer arithmetic on the fields.
    function automatic logic [67:0] model(input logic [31:0] i, input int xl);
        longint     v  = 0;
        logic [2:0] f  = 3'd0;
        logic       il = 1'b0;
        logic       sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
        longint     ival = longint'(i[31:20]) - (i[31] ? 64'sd4096 : 64'sd0);
        case (i[6:0])
            7'h13: begin
                if (sh) begin f = 3'd6; v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]); end
                else    begin f = 3'd1; v = ival; end
            end
            7'h03, 7'h67: begin f = 3'd1; v = ival; end
            7'h23: begin
                f = 3'd2;
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - (i[31] ? 64'sd4096 : 64'sd0);
            end
            7'h63: begin
                f = 3'd3;
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
                    - (i[31] ? 64'sd4096 : 64'sd0);
            end
            7'h37, 7'h17: begin
                f = 3'd4;
                v = longint'(i[31:12]) * 4096 - (i[31] ? 64'sd4294967296 : 64'sd0);
            end
            7'h6F: begin
                f = 3'd5;
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
                    - (i[31] ? 64'sd1048576 : 64'sd0);
            end
            7'h1B: begin
                if (xl != 64) il = 1'b1;
                else if (sh)  begin f = 3'd6; v = longint'(i[24:20]); end
                else          begin f = 3'd1; v = ival; end
            end
            7'h3B:                il = (xl != 64);
            7'h33, 7'h0F, 7'h73:  il = 1'b0;
            default:              il = 1'b1;
        endcase
        if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {v, f, il};
    endfunction

    function automatic logic [67:0] pk(input logic [63:0] i, input logic [2:0] f, input logic l);
        return {i, f, l};
    endfunction

    task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and stall-stability checker for both instances.
    always @(negedge clk) begin
        logic [67:0] got, exp;
        for (int k = 0; k < 2; k++) begin
            got = {oimm[k], ofmt[k], oill[k]};
            if (rst) begin
                sbq[k].delete();
                held[k] = 1'b0;
            end else begin
                if (held[k] && ovld[k]) chk($sformatf("stable%0d", k), got, hval[k]);
                if (ovld[k] && ordy[k]) begin
                    if (sbq[k].size() == 0) chk($sformatf("spurious%0d", k), 68'd1, 68'd0);
                    else begin
                        exp = sbq[k].pop_front();
                        chk($sformatf("order%0d", k), got, exp);
                    end
                end
                held[k] = ovld[k] && !ordy[k];
                hval[k] = got;
                if (vld[k] && irdy[k]) sbq[k].push_back(model(inst[k], (k == 0) ? 32 : 64));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d32_in  [7] = '{32'hFFF00093, 32'h4030D093, 32'hFE20AE23, 32'hFE000CE3,
                                 32'h001000EF, 32'h123452B7, 32'h0000001B};
    logic [67:0] d32_exp [7];
    logic [31:0] d64_in  [3] = '{32'h800002B7, 32'h03F0D093, 32'h4030D09B};
    logic [67:0] d64_exp [3];

    initial begin
        logic [31:0] r;
        logic        acc;
        d32_exp = '{pk(64'hFFFFFFFF, 3'd1, 1'b0), pk(64'h3, 3'd6, 1'b0), pk(64'hFFFFFFFC, 3'd2, 1'b0),
                    pk(64'hFFFFFFF8, 3'd3, 1'b0), pk(64'h800, 3'd5, 1'b0),
                    pk(64'h12345000, 3'd4, 1'b0), pk(64'h0, 3'd0, 1'b1)};
        d64_exp = '{pk(64'hFFFFFFFF80000000, 3'd4, 1'b0), pk(64'd63, 3'd6, 1'b0),
                    pk(64'd3, 3'd6, 1'b0)};
        inst[0] = '0;
        inst[1] = '0;

        // pin the model against hand-computed values
        chk("model_addi", model(32'hFFF00093, 32), pk(64'hFFFFFFFF, 3'd1, 1'b0));
        chk("model_beq",  model(32'hFE000CE3, 32), pk(64'hFFFFFFF8, 3'd3, 1'b0));
        chk("model_lui64", model(32'h800002B7, 64), pk(64'hFFFFFFFF80000000, 3'd4, 1'b0));
        chk("model_srli63", model(32'h03F0D093, 64), pk(64'd63, 3'd6, 1'b0));

        tick();
        chk("rst_ready", {66'd0, irdy}, 68'd0);
        tick();
        chk("rst_ovld", {66'd0, ovld}, 68'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {66'd0, irdy}, 68'd3);
        chk("rst_out0", {oimm[0], ofmt[0], oill[0]}, 68'd0);
        chk("rst_out1", {oimm[1], ofmt[1], oill[1]}, 68'd0);

        // back-to-back directed vectors, one cycle latency
        ordy = 2'b11;
        vld[0] = 1'b1;
        for (int n = 0; n < 7; n++) begin
            inst[0] = d32_in[n];
            tick();
            chk($sformatf("d32_vld%0d", n), {67'd0, ovld[0]}, 68'd1);
            chk($sformatf("d32_%0d", n), {oimm[0], ofmt[0], oill[0]}, d32_exp[n]);
        end
        vld[0] = 1'b0;
        vld[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            inst[1] = d64_in[n];
            tick();
            chk($sformatf("d64_%0d", n), {oimm[1], ofmt[1], oill[1]}, d64_exp[n]);
        end
        vld[1] = 1'b0;
        tick();
        tick();

        // skid fill: A, B accepted, C held while stalled
        ordy[0] = 1'b0;
        vld[0]  = 1'b1;
        inst[0] = 32'hFFF00093;
        tick();
        inst[0] = 32'h4030D093;
        tick();
        chk("skid_ready_two", {67'd0, irdy[0]}, 68'd0);
        inst[0] = 32'hFE20AE23;
        tick();
        chk("skid_ready_held", {67'd0, irdy[0]}, 68'd0);
        chk("skid_A", {oimm[0], ofmt[0], oill[0]}, pk(64'hFFFFFFFF, 3'd1, 1'b0));
        ordy[0] = 1'b1;
        tick();
        chk("skid_B", {oimm[0], ofmt[0], oill[0]}, pk(64'h3, 3'd6, 1'b0));
        tick();
        chk("skid_C", {oimm[0], ofmt[0], oill[0]}, pk(64'hFFFFFFFC, 3'd2, 1'b0));
        vld[0] = 1'b0;
        tick();
        chk("skid_drained", {67'd0, ovld[0]}, 68'd0);

        // reset while two entries are held
        ordy[0] = 1'b0;
        vld[0]  = 1'b1;
        inst[0] = 32'h123452B7;
        tick();
        inst[0] = 32'hFE000CE3;
        tick();
        vld[0] = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_two_ready", {67'd0, irdy[0]}, 68'd0);
        tick();
        chk("rst_two_ovld", {67'd0, ovld[0]}, 68'd0);
        chk("rst_two_ready2", {67'd0, irdy[0]}, 68'd0);
        rst = 1'b0;
        #1;
        chk("rst_two_release", {67'd0, irdy[0]}, 68'd1);
        ordy[0] = 1'b1;
        vld[0]  = 1'b1;
        inst[0] = 32'h001000EF;
        tick();
        chk("rst_two_first", {oimm[0], ofmt[0], oill[0]}, pk(64'h800, 3'd5, 1'b0));
        vld[0] = 1'b0;
        tick();

        // SKID=0 with out_ready toggling every cycle
        ordy[1] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            r = $urandom();
            inst[1] = {r[31:7], pool[$urandom_range(0, 13)]};
            vld[1]  = 1'b1;
            acc     = 1'b0;
            for (int g = 0; g < 20 && !acc; g++) begin
                ordy[1] = ~ordy[1];
                #1;
                acc = irdy[1];
                tick();
            end
            if (!acc) chk("accept_timeout", {67'd0, acc}, 68'd1);
        end
        vld[1]  = 1'b0;
        ordy[1] = 1'b1;
        repeat (4) tick();
        chk("sb0_empty", 68'(sbq[0].size()), 68'd0);
        chk("sb1_empty", 68'(sbq[1].size()), 68'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RV32I/RV64I decode stage. It accepts raw instructions over a valid/ready handshake and produces the sign- or zero-extended immediate. It also emits a format tag and an illegal-opcode flag, with one cycle of latency and optional skid buffering. It sits between the fetch buffer and the register-read stage.

## Interface
- `XLEN`, 32 — immediate width; legal values 32 or 64.
- `SKID`, 1 — 1: two-entry skid buffer with registered `in_ready`; 0: single output register with combinational `in_ready`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — instruction present.
- `in_ready` out 1 — block accepts on `in_valid && in_ready`.
- `in_inst` in 32 — raw instruction word.
- `out_valid` out 1 — result present.
- `out_ready` in 1 — consumer accepts on `out_valid && out_ready`.
- `out_imm` out XLEN — extended immediate.
- `out_fmt` out 3 — `FMT_NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6` (shift amount).
- `out_illegal` out 1 — opcode not recognised for this XLEN.

## Operation
- Decode on `in_inst[6:0]`; `sext()` extends to XLEN from the top bit named.
- `0010011` OP-IMM:
  - funct3 `001`/`101` → SH, `imm = zext(inst[24:20])` for XLEN=32, `zext(inst[25:20])` for XLEN=64; `inst[31:26]` is ignored.
  - Any other funct3 (including SLTIU) → I, `sext(inst[31:20])`.
- `0000011` LOAD, `1100111` JALR → I, `sext(inst[31:20])`.
- `0100011` STORE → S, `sext({inst[31:25],inst[11:7]})`.
- `1100011` BRANCH → B, `sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})`.
- `0110111` LUI, `0010111` AUIPC → U, `sext({inst[31:12],12'b0})`; bits above 31 copy `inst[31]` for XLEN=64.
- `1101111` JAL → J, `sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
- `0011011` OP-IMM-32, XLEN=64 only → I or SH as above, with SH using a 5-bit shamt.
- `0110011` OP, `0111011` OP-32 (XLEN=64 only), `0001111` FENCE, `1110011` SYSTEM → NONE, `imm=0`, `illegal=0`.
- Any other opcode, or an XLEN=64-only opcode when XLEN=32 → NONE, `imm=0`, `illegal=1`; the word is still passed downstream.
- Results are delivered in strict acceptance order; nothing is dropped or duplicated.

## Timing
- Reset values: `out_valid=0`, `out_imm=0`, `out_fmt=NONE`, `out_illegal=0`, skid entries empty.
- `in_ready` is 0 in every cycle `rst` is high. It is 1 in the first cycle after reset.
- Latency: an instruction accepted in cycle N is presented with `out_valid=1` in cycle N+1.
- Throughput: one instruction per cycle while `out_ready=1`.
- SKID=0:
  - `in_ready = !rst && (!out_valid || out_ready)`.
  - The output register loads on accept.
  - `out_valid` clears when the output transfers with no new accept in the same cycle.
- SKID=1:
  - States are EMPTY (0 held), ONE (output register only), TWO (output plus skid entry).
  - EMPTY → ONE on accept.
  - ONE → ONE on accept plus transfer, → TWO on accept without transfer, → EMPTY on transfer without accept.
  - TWO → ONE on transfer; the skid entry moves to the output register.
  - `in_ready` is a register, equal to 1 exactly when the state is not TWO. No accept can occur in TWO.
- Simultaneous accept and transfer in ONE: new data replaces output data in the same edge.
- Output stability: `out_imm`, `out_fmt`, `out_illegal` hold while `out_valid && !out_ready`.
- Reset mid-operation: all held entries are discarded. `out_valid=0` on the cycle after `rst` is sampled high.

## Structure
- Package `imm_gen_pkg` holds:
  - the `imm_fmt_e` enum (3-bit);
  - the opcode localparams `OPC_OP_IMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_OP`, `OPC_OP_IMM32`, `OPC_OP32`, `OPC_FENCE`, `OPC_SYSTEM`.
- Sub-module `imm_decode` #(XLEN): purely combinational `inst` → `{imm, fmt, illegal}`.
- `imm_gen_pipe` instantiates `imm_decode` once, on the input side, and registers its result. Skid and output registers store decoded results, not raw instructions.

## Test plan
- XLEN=32, `out_ready=1`: `0xFFF00093` (addi -1) → next cycle `imm=0xFFFFFFFF`, fmt I; `0x4030D093` (srai 3) → `imm=0x00000003`, fmt SH.
- `0xFE20AE23` (sw -4) → `0xFFFFFFFC` S; `0xFE000CE3` (beq -8) → `0xFFFFFFF8` B; `0x001000EF` (jal +2048) → `0x00000800` J; `0x123452B7` (lui) → `0x12345000` U.
- XLEN=64:
  - `0x800002B7` → `imm=0xFFFFFFFF80000000`;
  - `0x03F0D093` (srli 63) → `imm=63`;
  - XLEN=32 with opcode `0011011` → `illegal=1`, `imm=0`.
- SKID=1, back-to-back stream `A,B,C` with `out_ready=0` for 3 cycles:
  - A and B are accepted and `in_ready` drops to 0; C is held.
  - After `out_ready=1`, outputs appear as A, B, C on consecutive cycles.
- SKID=0, `out_ready` toggled every cycle for 20 random instructions → every result matches the scoreboard in order, and outputs stay stable while stalled.
- Assert `rst` in state TWO → next cycle `out_valid=0`, `in_ready=0`; after release, `in_ready=1` and the first new instruction emerges with correct immediate.
